register_bank_int: RTL and testbench
====================================

# register_bank_int

Parametrised multi-register bank: the successor to the single tick-gated register with preset and chip-select tri-state output. Holds `NrOfRegs` words of `NrOfBits` bits, with one bit-masked write port and two registered read ports that drive shared buses through per-port chip selects. It adds per-register dirty tracking and optional write-to-read forwarding. It sits in the memory section beside the single-register primitives and serves as a small general-purpose / game-state register file on the CPU data buses.

## Interface
- `NrOfBits`, 32, word width (1..64)
- `NrOfRegs`, 8, number of registers (2..256, need not be a power of two)
- `AddrBits`, 3, address width; must be at least clog2(`NrOfRegs`)
- `ActiveLevel`, 1, polarity of `we`: 1 = active-high, 0 = active-low
- `Clock` in 1, single clock; all state updates on its rising edge
- `Reset` in 1, synchronous, active-high; highest priority
- `ClockEnable` in 1, global enable; gates writes and read-register capture
- `Tick` in 1, write qualifier (from the tick generator); writes need `ClockEnable & Tick`
- `pre` in 1, synchronous preset of all registers to all-ones
- `we` in 1, write enable, polarity set by `ActiveLevel`
- `waddr` in `AddrBits`, write address
- `D` in `NrOfBits`, write data
- `WMask` in `NrOfBits`, bit write mask (1 = bit written)
- `DirtyClr` in 1, clears all dirty flags
- `raddrA`, `raddrB` in `AddrBits`, read addresses
- `csA`, `csB` in 1, chip selects; when low the port floats (Z)
- `QA`, `QB` out `NrOfBits`, registered read data, tri-stated by `csA`/`csB`
- `Dirty` out `NrOfRegs`, per-register "written since last clear" flags

## Operation
- Write fires when `ClockEnable & Tick` and `we` equals `ActiveLevel`. The new value is `(old & ~WMask) | (D & WMask)`.
- Priority, per edge: `Reset` (all registers, read registers and `Dirty` go to 0) > `pre` (all registers go to all-ones; read registers follow the capture rule; `Dirty` unchanged) > write.
- `pre` and `Reset` ignore `ClockEnable` and `Tick`.
- Out-of-range address (>= `NrOfRegs`):
  - a write is dropped and sets no dirty flag;
  - a read captures 0.
- `WMask` = 0 with a firing write: the data is unchanged, but `Dirty[waddr]` is still set (the access is recorded).
- Dirty flags:
  - set on a firing in-range write;
  - `DirtyClr` clears all flags;
  - if a write and `DirtyClr` happen in the same cycle, the written register's flag ends set and all others are cleared.
- Read capture happens on every edge where `ClockEnable` is high (it does not need `Tick`). Each port captures the addressed register independently; `raddrA == raddrB` is legal.
- `QA = csA ? rdA : Z` and `QB = csB ? rdB : Z`. These are combinational from the chip select; a chip select never affects state.

## Timing
- Read latency is 1 cycle: the value at `raddrA` on edge N appears on `QA` after edge N.
- Write latency is 1 cycle. A read of the same address on the next edge returns the new value.
- A write and a read of the same address on the same edge: behaviour depends on `REGBANK_BYPASS_EN` (see Configuration).
- Reset values: `QA`/`QB` = 0 when selected, else Z; `Dirty` = 0; all registers = 0.
- Reset asserted mid-sequence takes effect on that edge. A write pending in the same cycle is lost.
- `ClockEnable` low: all read data, registers and dirty flags hold. Only `Reset`, `pre` and `DirtyClr` act.

## Configuration
- `REGBANK_BYPASS_EN` defined: each read register captures the **next-state** value of the addressed register. This forwards:
  - a same-edge write, with its merged masked value;
  - a same-edge `pre` (all-ones).
- `REGBANK_BYPASS_EN` undefined: each read register captures the **current-state** (pre-edge) value. A same-edge write becomes visible one cycle later.
- The macro has no other effect. The port list is identical in both builds.

## Test plan
- Reset and preset:
  - assert `Reset` for 1 cycle with `csA`=1, `csB`=0 -> `QA`=0, `QB`=Z, `Dirty`=0;
  - then `pre` with `raddrA`=5 -> next cycle `QA`=all-ones, `Dirty` unchanged.
- Masked write and dirty flags, `NrOfBits`=32, reg 3 = 0x00000000, `Tick`=1:
  - write `D`=0xFFFFFFFF, `WMask`=0x0000FF00 -> read of reg 3 gives 0x0000FF00, `Dirty`=0x08;
  - with `Tick`=0, the same write -> no change.
- Same-edge read/write to reg 2 (old 0x11, new 0x22):
  - with `REGBANK_BYPASS_EN` -> `QA`=0x22 one cycle later;
  - without it -> `QA`=0x11, then 0x22 on the following read.
- Out of range, `NrOfRegs`=6:
  - write to address 7 -> no register or `Dirty` change;
  - read of address 7 -> `QA`=0.
- Dirty clear race: `Dirty`=0x0C, write reg 0 together with `DirtyClr` -> `Dirty`=0x01.
- Polarity and enables, `ActiveLevel`=0:
  - `we`=0 with `ClockEnable`=1, `Tick`=1 writes;
  - `we`=1 does not write;
  - `ClockEnable`=0 holds `QA` while `raddrA` changes.

Source files
------------

// File: rtl/register_bank_int.sv
// register_bank_int: bit-masked register file with two registered tri-state read ports and dirty flags.
// REGBANK_BYPASS_EN: read ports capture the next-state value, forwarding same-edge writes and presets.
module register_bank_int #(
    parameter int NrOfBits    = 32,
    parameter int NrOfRegs    = 8,
    parameter int AddrBits    = 3,
    parameter bit ActiveLevel = 1'b1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                ClockEnable,
    input  logic                Tick,
    input  logic                pre,
    input  logic                we,
    input  logic [AddrBits-1:0] waddr,
    input  logic [NrOfBits-1:0] D,
    input  logic [NrOfBits-1:0] WMask,
    input  logic                DirtyClr,
    input  logic [AddrBits-1:0] raddrA,
    input  logic [AddrBits-1:0] raddrB,
    input  logic                csA,
    input  logic                csB,
    output logic [NrOfBits-1:0] QA,
    output logic [NrOfBits-1:0] QB,
    output logic [NrOfRegs-1:0] Dirty
);
    logic [NrOfBits-1:0] r_regs [NrOfRegs];
    logic [NrOfBits-1:0] w_next [NrOfRegs];
    logic [NrOfBits-1:0] w_src  [NrOfRegs];
    logic [NrOfBits-1:0] r_rd_a, r_rd_b, w_rd_a, w_rd_b;
    logic [NrOfRegs-1:0] r_dirty, w_hit;
    logic                w_wr;

    assign w_wr = ClockEnable & Tick & (we == ActiveLevel) & ~pre;

    // Out-of-range addresses match no index, so such writes drop and such reads return 0.
    always_comb begin
        for (int i = 0; i < NrOfRegs; i++) begin
            w_hit[i]  = w_wr && (waddr == AddrBits'(i));
            w_next[i] = pre ? '1 : w_hit[i] ? (r_regs[i] & ~WMask) | (D & WMask) : r_regs[i];
        end
    end

`ifdef REGBANK_BYPASS_EN
    assign w_src = w_next;
`else
    assign w_src = r_regs;
`endif

    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < NrOfRegs; i++) begin
            if (raddrA == AddrBits'(i)) w_rd_a = w_src[i];
            if (raddrB == AddrBits'(i)) w_rd_b = w_src[i];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < NrOfRegs; i++) r_regs[i] <= '0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_dirty <= '0;
        end else begin
            r_regs  <= w_next;
            r_dirty <= (DirtyClr ? '0 : r_dirty) | w_hit;
            if (ClockEnable) begin
                r_rd_a <= w_rd_a;
                r_rd_b <= w_rd_b;
            end
        end
    end

    assign QA    = csA ? r_rd_a : 'z;
    assign QB    = csB ? r_rd_b : 'z;
    assign Dirty = r_dirty;
endmodule

// File: tb/tb_register_bank_int.sv
// tb_register_bank_int: directed checks of register_bank_int (6 regs, active-low we).
module tb_register_bank_int;
    logic        clk = 1'b0;
    logic        Reset, ClockEnable, Tick, pre, we, DirtyClr, csA, csB;
    logic [2:0]  waddr, raddrA, raddrB;
    logic [31:0] D, WMask;
    wire  [31:0] QA, QB;
    wire  [5:0]  Dirty;
    int          checks = 0;
    int          errors = 0;

    register_bank_int #(.NrOfBits(32), .NrOfRegs(6), .AddrBits(3), .ActiveLevel(1'b0)) dut (
        .Clock(clk), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick), .pre(pre),
        .we(we), .waddr(waddr), .D(D), .WMask(WMask), .DirtyClr(DirtyClr),
        .raddrA(raddrA), .raddrB(raddrB), .csA(csA), .csB(csB),
        .QA(QA), .QB(QB), .Dirty(Dirty)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] m);
        we = 1'b0; waddr = a; D = d; WMask = m;
        step();
        we = 1'b1;
    endtask

    initial begin
        Reset = 1'b1; ClockEnable = 1'b1; Tick = 1'b1; pre = 1'b0; we = 1'b1; DirtyClr = 1'b0;
        csA = 1'b1; csB = 1'b0; waddr = '0; raddrA = '0; raddrB = '0; D = '0; WMask = '0;
        step();
        Reset = 1'b0;
        chk("reset_qa", QA, 32'h0);
        chk("reset_dirty", {26'h0, Dirty}, 32'h0);
        checks++;
        assert (QB === 32'hzzzzzzzz) else begin
            errors++;
            $error("FAIL reset_qb_z observed=%h expected=zzzzzzzz", QB);
        end
        csB = 1'b1;
        #1;
        chk("reset_qb_sel", QB, 32'h0);

        pre = 1'b1; raddrA = 3'd5;
        step();
        pre = 1'b0;
`ifdef REGBANK_BYPASS_EN
        chk("pre_same_edge", QA, 32'hffffffff);
`else
        chk("pre_same_edge", QA, 32'h0);
`endif
        step();
        chk("pre_qa", QA, 32'hffffffff);
        chk("pre_dirty", {26'h0, Dirty}, 32'h0);

        wr(3'd3, 32'h0, 32'hffffffff);
        chk("dirty_set", {26'h0, Dirty}, 32'h08);
        DirtyClr = 1'b1;
        step();
        DirtyClr = 1'b0;
        chk("dirty_clr", {26'h0, Dirty}, 32'h0);

        raddrA = 3'd3;
        wr(3'd3, 32'hffffffff, 32'h0000ff00);
        step();
        chk("masked_wr", QA, 32'h0000ff00);
        chk("masked_dirty", {26'h0, Dirty}, 32'h08);
        Tick = 1'b0;
        wr(3'd3, 32'h0, 32'hffffffff);
        Tick = 1'b1;
        step();
        chk("no_tick_data", QA, 32'h0000ff00);

        wr(3'd2, 32'h11, 32'hffffffff);
        raddrA = 3'd2; raddrB = 3'd2;
        wr(3'd2, 32'h22, 32'hffffffff);
`ifdef REGBANK_BYPASS_EN
        chk("fwd_qa", QA, 32'h22);
        chk("fwd_qb", QB, 32'h22);
`else
        chk("fwd_qa", QA, 32'h11);
        chk("fwd_qb", QB, 32'h11);
`endif
        step();
        chk("after_wr_qa", QA, 32'h22);
        chk("race_pre_dirty", {26'h0, Dirty}, 32'h0c);

        wr(3'd7, 32'h0, 32'hffffffff);
        chk("oor_wr_dirty", {26'h0, Dirty}, 32'h0c);
        raddrA = 3'd7; raddrB = 3'd3;
        step();
        chk("oor_rd", QA, 32'h0);
        chk("oor_reg3", QB, 32'h0000ff00);
        raddrA = 3'd6; raddrB = 3'd5;
        step();
        chk("oor_rd6", QA, 32'h0);
        chk("oor_reg5", QB, 32'hffffffff);

        DirtyClr = 1'b1;
        wr(3'd0, 32'ha5a5a5a5, 32'hffffffff);
        DirtyClr = 1'b0;
        chk("dirty_race", {26'h0, Dirty}, 32'h01);

        we = 1'b1; waddr = 3'd4; D = 32'h0; WMask = 32'hffffffff;
        step();
        raddrA = 3'd4;
        step();
        chk("we_inactive", QA, 32'hffffffff);
        chk("we_inactive_dirty", {26'h0, Dirty}, 32'h01);

        raddrA = 3'd0;
        step();
        chk("rd_reg0", QA, 32'ha5a5a5a5);
        ClockEnable = 1'b0; raddrA = 3'd4;
        wr(3'd0, 32'h0, 32'hffffffff);
        chk("ce_hold_qa", QA, 32'ha5a5a5a5);
        chk("ce_hold_dirty", {26'h0, Dirty}, 32'h01);
        DirtyClr = 1'b1;
        step();
        DirtyClr = 1'b0;
        chk("ce_dirtyclr", {26'h0, Dirty}, 32'h0);
        ClockEnable = 1'b1; raddrA = 3'd0;
        step();
        chk("ce_no_wr", QA, 32'ha5a5a5a5);

        Reset = 1'b1;
        wr(3'd1, 32'h33, 32'hffffffff);
        Reset = 1'b0;
        chk("mid_reset_qa", QA, 32'h0);
        raddrA = 3'd1; raddrB = 3'd0;
        step();
        chk("mid_reset_reg1", QA, 32'h0);
        chk("mid_reset_reg0", QB, 32'h0);
        chk("mid_reset_dirty", {26'h0, Dirty}, 32'h0);
        csA = 1'b0;
        #1;
        checks++;
        assert (QA === 32'hzzzzzzzz) else begin
            errors++;
            $error("FAIL csa_low_z observed=%h expected=zzzzzzzz", QA);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
